// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler: grants one source per frame and streams its bytes onto a shared TX channel.
// Define TX_SCHED_CRC_EN to append a CRC-16/CCITT-FALSE trailer (high byte, then low byte) to each frame.
module tx_frame_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_REQ-1:0]       send_data_i,
   input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
   input  logic [NUM_REQ*8-1:0]     src_data_i,
   input  logic [NUM_REQ-1:0]       src_valid_i,
   output logic [NUM_REQ-1:0]       src_ready_o,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [7:0]               tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic                     tx_last_o,
   output logic                     busy_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

`ifdef TX_SCHED_CRC_EN
   typedef enum logic [1:0] {IDLE, PAYLOAD, CRC1, CRC2} state_t;
`else
   typedef enum logic [1:0] {IDLE, PAYLOAD} state_t;
`endif

   state_t             state_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [IDX_W-1:0]   gidx_q;
   logic [IDX_W-1:0]   last_q;
   logic [LEN_W-1:0]   cnt_q;
   logic               busy_q;
`ifdef TX_SCHED_CRC_EN
   logic [15:0]        crc_q;
`endif

   logic [7:0]       src_byte [NUM_REQ];
   logic [LEN_W-1:0] len_arr  [NUM_REQ];
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] arb_idx;
   logic             beat;
   logic             frame_done;

`ifdef TX_SCHED_CRC_EN
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--)
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      return r;
   endfunction
`endif

   always_comb begin
      for (int s = 0; s < NUM_REQ; s++) begin
         src_byte[s] = src_data_i[s*8 +: 8];
         len_arr[s]  = req_len_i[s*LEN_W +: LEN_W];
      end
   end

   // First requester found walking upward from the source after the last grant.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      arb_idx  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         arb_idx = IDX_W'((int'(last_q) + i) % NUM_REQ);
         if (!pick_vld && send_data_i[arb_idx]) begin
            pick_vld = 1'b1;
            pick_idx = arb_idx;
         end
      end
   end

   always_comb begin
      tx_data_o   = '0;
      tx_valid_o  = 1'b0;
      tx_last_o   = 1'b0;
      src_ready_o = '0;
      case (state_q)
         PAYLOAD: if (cnt_q != '0) begin
            tx_data_o           = src_byte[gidx_q];
            tx_valid_o          = src_valid_i[gidx_q];
            src_ready_o[gidx_q] = tx_ready_i;
`ifndef TX_SCHED_CRC_EN
            tx_last_o           = src_valid_i[gidx_q] && (cnt_q == LEN_W'(1));
`endif
         end
`ifdef TX_SCHED_CRC_EN
         CRC1: begin
            tx_valid_o = 1'b1;
            tx_data_o  = crc_q[15:8];
         end
         CRC2: begin
            tx_valid_o = 1'b1;
            tx_data_o  = crc_q[7:0];
            tx_last_o  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign beat = tx_valid_o & tx_ready_i;

   // A zero count in PAYLOAD is a zero-length grant: hold gnt one cycle and release.
   always_comb begin
      frame_done = 1'b0;
      case (state_q)
`ifdef TX_SCHED_CRC_EN
         PAYLOAD: frame_done = (cnt_q == '0);
         CRC2:    frame_done = tx_ready_i;
`else
         PAYLOAD: frame_done = (cnt_q == '0) || (beat && cnt_q == LEN_W'(1));
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         last_q  <= IDX_W'(NUM_REQ-1);
         cnt_q   <= '0;
         busy_q  <= 1'b0;
`ifdef TX_SCHED_CRC_EN
         crc_q   <= 16'hFFFF;
`endif
      end else begin
         case (state_q)
            IDLE: if (pick_vld) begin
               gnt_q  <= NUM_REQ'(1) << pick_idx;
               gidx_q <= pick_idx;
               cnt_q  <= len_arr[pick_idx];
               busy_q <= 1'b1;
`ifdef TX_SCHED_CRC_EN
               crc_q   <= 16'hFFFF;
               state_q <= (len_arr[pick_idx] == '0) ? CRC1 : PAYLOAD;
`else
               state_q <= PAYLOAD;
`endif
            end
            PAYLOAD: if (beat) begin
               cnt_q <= cnt_q - LEN_W'(1);
`ifdef TX_SCHED_CRC_EN
               crc_q <= crc_byte(crc_q, tx_data_o);
               if (cnt_q == LEN_W'(1)) state_q <= CRC1;
`endif
            end
`ifdef TX_SCHED_CRC_EN
            CRC1: if (tx_ready_i) state_q <= CRC2;
`endif
            default: ;
         endcase
         if (frame_done) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= gidx_q;
         end
      end
   end

   assign gnt_o  = gnt_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: expected beats queued at stimulus time, popped per accepted byte.
module tb_tx_frame_scheduler;
   localparam int N  = 4;
   localparam int LW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    send_data;
   logic [N*LW-1:0] req_len;
   logic [N*8-1:0]  src_data;
   logic [N-1:0]    src_valid, src_ready, gnt;
   logic [7:0]      tx_data;
   logic            tx_valid, tx_ready, tx_last, busy;

   tx_frame_scheduler #(.NUM_REQ(N), .LEN_W(LW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .send_data_i(send_data), .req_len_i(req_len),
      .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(src_ready),
      .gnt_o(gnt), .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .tx_last_o(tx_last), .busy_o(busy)
   );

   int ncmp = 0;
   int nfail = 0;
   int beats = 0;
   logic [12:0] sb_q[$];
   int ptr[N];
   int exp_ptr[N];
   logic tgl, tgl_en;

   function automatic logic [7:0] mem_byte(int s, int k);
      return (s == 1) ? 8'(32'h31 + k) : 8'(32'h40 * s + 5 + k);
   endfunction

`ifdef TX_SCHED_CRC_EN
   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--)
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      return r;
   endfunction
`endif

   // Source model: each source walks its own byte table as bytes are accepted.
   always_comb begin
      src_data = '0;
      for (int s = 0; s < N; s++) src_data[s*8 +: 8] = mem_byte(s, ptr[s]);
   end
   assign src_valid = tgl_en ? {N{tgl}} : {N{1'b1}};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < N; s++) ptr[s] <= 0;
         tgl <= 1'b1;
      end else begin
         tgl <= ~tgl;
         for (int s = 0; s < N; s++) if (src_ready[s] && src_valid[s]) ptr[s] <= ptr[s] + 1;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
         if (tx_valid && tx_ready) begin
            beats++;
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) chk("beat", 32'({tx_data, tx_last, gnt}), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [7:0] d, logic l, int s);
      sb_q.push_back({d, l, N'(1) << s});
   endtask

   task automatic push_frame(int s, int len);
      logic [7:0] d;
`ifdef TX_SCHED_CRC_EN
      logic [15:0] c;
      c = 16'hFFFF;
`endif
      for (int k = 0; k < len; k++) begin
         d = mem_byte(s, exp_ptr[s]);
         exp_ptr[s]++;
`ifdef TX_SCHED_CRC_EN
         push(d, 1'b0, s);
         c = crc_model(c, d);
`else
         push(d, k == len - 1, s);
`endif
      end
`ifdef TX_SCHED_CRC_EN
      push(c[15:8], 1'b0, s);
      push(c[7:0], 1'b1, s);
`endif
   endtask

   // "123456789" on source 1, with the known CRC-16/CCITT-FALSE check value.
   task automatic push_check_frame();
      for (int k = 0; k < 9; k++) push(8'(32'h31 + k), (k == 8) ? 1'b1 : 1'b0, 1);
      exp_ptr[1] += 9;
`ifdef TX_SCHED_CRC_EN
      sb_q[$] = {8'h39, 1'b0, 4'b0010};
      push(8'h29, 1'b0, 1);
      push(8'hB1, 1'b1, 1);
`endif
   endtask

   task automatic wait_gnt(int s);
      int n;
      n = 0;
      while (gnt == '0 && n < 100) begin tick(); n++; end
      chk("gnt", 32'(gnt), 32'(N'(1) << s));
   endtask

   task automatic wait_gnt_low();
      int n;
      n = 0;
      while (gnt != '0 && n < 100) begin tick(); n++; end
      chk("gnt_low", 32'(gnt), 32'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < 300) begin tick(); n++; end
      chk("drain_left", 32'(sb_q.size()), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({gnt, src_ready, tx_data, tx_valid, tx_last, busy}), 32'd0);
      sb_q.delete();
      send_data = '0;
      for (int s = 0; s < N; s++) exp_ptr[s] = 0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst", 32'({busy, gnt}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, n;
      send_data = '0;
      req_len   = '0;
      tx_ready  = 1'b1;
      tgl_en    = 1'b0;
      for (int s = 0; s < N; s++) exp_ptr[s] = 0;
      tick();
      chk("reset_state", 32'({gnt, src_ready, tx_data, tx_valid, tx_last, busy}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_after_reset", 32'({busy, gnt}), 32'd0);

      // Check frame on source 1; grant appears one cycle after the request.
      req_len[1*LW +: LW] = 8'd9;
      push_check_frame();
      send_data = 4'b0010;
      tick();
      chk("gnt_latency", 32'(gnt), 32'b0010);
      send_data = '0;
      drain();

      // All sources requesting: round robin from source 0 after reset.
      do_reset();
      for (int s = 0; s < N; s++) req_len[s*LW +: LW] = 8'd2;
      push_frame(0, 2); push_frame(1, 2); push_frame(2, 2); push_frame(3, 2); push_frame(0, 2);
      send_data = '1;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(k % N);
         if (k == 4) send_data = '0;
         else wait_gnt_low();
      end
      drain();

      // Back-pressure: data must hold while tx_ready is low.
      do_reset();
      req_len[1*LW +: LW] = 8'd9;
      push_check_frame();
`ifdef TX_SCHED_CRC_EN
      b0 = beats;
      send_data = 4'b0010;
      wait_gnt(1);
      send_data = '0;
      n = 0;
      while (beats != b0 + 9 && n < 100) begin tick(); n++; end
      tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", 32'(tx_valid), 32'd1);
         chk("stall_data", 32'(tx_data), 32'h29);
      end
`else
      tx_ready = 1'b0;
      send_data = 4'b0010;
      wait_gnt(1);
      send_data = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", 32'(tx_valid), 32'd1);
         chk("stall_data", 32'(tx_data), 32'h31);
      end
`endif
      tx_ready = 1'b1;
      drain();

      // Zero-length grant on source 2.
      req_len[2*LW +: LW] = 8'd0;
      send_data = 4'b0100;
      tick();
      chk("zl_gnt", 32'(gnt), 32'b0100);
`ifdef TX_SCHED_CRC_EN
      push(8'hFF, 1'b0, 2);
      push(8'hFF, 1'b1, 2);
      send_data = '0;
`else
      chk("zl_valid", 32'(tx_valid), 32'd0);
      send_data = '0;
      tick();
      chk("zl_gnt_drop", 32'({gnt, tx_valid}), 32'd0);
`endif
      drain();

      // Source 0 with src_valid toggling every cycle.
      tgl_en = 1'b1;
      req_len[0 +: LW] = 8'd4;
      b0 = beats;
      push_frame(0, 4);
      send_data = 4'b0001;
      wait_gnt(0);
      send_data = '0;
      drain();
`ifdef TX_SCHED_CRC_EN
      chk("toggle_beats", 32'(beats - b0), 32'd6);
`else
      chk("toggle_beats", 32'(beats - b0), 32'd4);
`endif
      tgl_en = 1'b0;

      // Reset after two beats of a fresh frame; pointer returns to source 0.
      b0 = beats;
      push_frame(0, 4);
      send_data = 4'b0001;
      wait_gnt(0);
      send_data = '0;
      n = 0;
      while (beats != b0 + 2 && n < 100) begin tick(); n++; end
      chk("busy_midframe", 32'(busy), 32'd1);
      do_reset();
      req_len[0 +: LW] = 8'd1;
      req_len[1*LW +: LW] = 8'd1;
      push_frame(0, 1);
      send_data = 4'b0011;
      wait_gnt(0);
      send_data = '0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
